fp_div_seq: RTL and testbench
=============================

// Module: fp_div_seq
// PURPOSE
//  Iterative IEEE-754 single-precision divider, A/B, exactly rounded (RNE). Restoring
//  mantissa long division, one quotient bit per cycle. Multi-cycle, area-lean companion
//  to the combinational Newton-Raphson divide path; sits behind valid/ready handshakes.
//  Exact results are the golden reference for the reciprocal-based path.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 supported (8-bit exp, 23-bit frac)
// PORTS
//  clk        in   1     rising-edge clock; sole clock
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operands a,b valid
//  in_ready   out  1     high only in IDLE; 0 while rst high
//  a          in   XLEN  dividend
//  b          in   XLEN  divisor
//  out_valid  out  1     result and flags valid
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  quotient
//  overflow   out  1     finite result too large, returned as +/-inf
//  underflow  out  1     result below min normal, flushed to +/-0
//  exception  out  1     NaN operand, 0/0, inf/inf, or finite-nonzero/0
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid, result, overflow, underflow, exception = 0.
//    rst in any state aborts the op; in_ready=1 from the first cycle after rst drops.
//  - FSM: IDLE -> UNPACK (on in_valid&in_ready; latch a,b) -> DIVIDE (25 cyc) -> ROUND
//    -> DONE. UNPACK -> DONE directly for special cases. DONE -> IDLE on out_ready.
//  - Latency: accept at edge N; normal out_valid=1 from N+28; special from N+2.
//    Min issue interval 29 cycles normal, 3 special (includes IDLE cycle).
//  - result/flags stable while out_valid & !out_ready; out_valid drops edge after accept.
//  - Denormal inputs treated as signed zero (flush-to-zero). sign = a[31]^b[31].
//  - Special (priority order): any NaN, 0/0, inf/inf -> 32'h7FC00000, exception=1;
//    finite/0 -> +/-inf, exception=1; inf/x -> +/-inf; 0/x or x/inf -> +/-0 (flags 0).
//  - UNPACK: ma={1,a frac}, mb={1,b frac} (24b); e = Ea-Eb+127 as 10-bit signed;
//    if ma<mb: ma<<=1, e-=1 (quotient in [1,2)).
//  - DIVIDE: rem init ma (26b); per cycle: if rem>=mb {q bit=1; rem-=mb}; rem<<=1.
//    25 cycles give q[24:0] = 24 mantissa bits + guard; sticky = (rem!=0).
//  - ROUND: RNE on guard/sticky with lsb tie-break; mantissa carry-out -> frac=0, e+=1.
//    e>=255 -> +/-inf, overflow=1. e<=0 -> +/-0, underflow=1. Else {sign,e[7:0],frac}.
//  - Only one flag may be high per result; flags clear when a new op is accepted.
//  - in_valid while busy is ignored (not queued); a,b only sampled in IDLE.
// TESTING
//  T1: a=40C00000 (6.0), b=40000000 -> 40400000 at N+28, flags 0; 28-cycle count checked.
//  T2: a=3F800000, b=40400000 (1/3) -> 3EAAAAAB (round-up); C0E00000/40000000 -> C0600000.
//  T3: a=3F800000, b=00000000 -> 7F800000, exception=1, out_valid at N+2;
//      a=00000000, b=00000000 -> 7FC00000, exception=1.
//  T4: a=7F000000, b=3E800000 -> 7F800000, overflow=1; a=00800000, b=40000000 ->
//      00000000, underflow=1.
//  T5: out_ready=0 for 10 cycles after out_valid -> result/flags constant, in_ready=0;
//      in_valid pulsed during DIVIDE ignored; then out_ready=1 -> IDLE next cycle.
//  T6: rst=1 at cycle N+10 of an op -> out_valid=0, result=0; new op 40400000/3F800000
//      after rst -> 40400000 with correct latency.

Source files
------------

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider (A/B), round-to-nearest-even.
// Restoring long division on the 24-bit mantissas, one quotient bit per cycle,
// behind valid/ready handshakes. Denormal operands are flushed to signed zero.
module fp_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] e_q;
    logic [23:0]       mb_q;
    logic [25:0]       rem_q;
    // Only the low 24 quotient bits are kept: the leading bit is always 1 and
    // shifts out on the final iteration, leaving {frac[22:0], guard}.
    logic [23:0]       q_q;
    logic [4:0]        cnt_q;

    // Operand classification
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              is_special;
    logic              sign_ab;
    logic [23:0]       ma, mb;
    logic              ma_lt;
    logic signed [9:0] e_raw, e_init;
    logic [25:0]       rem_init;
    logic [31:0]       special_res;
    logic              special_exc;

    // Divide step
    logic              rem_ge;
    logic [25:0]       rem_sub, rem_next;

    // Rounding
    logic              guard, sticky, lsb, inc;
    logic [23:0]       frac_sum;
    logic              frac_carry;
    logic signed [9:0] e_rnd;
    logic              rnd_ovf, rnd_unf;

    // Unpack the latched operands and resolve the special-case result
    always_comb begin
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        fa       = a_q[22:0];
        fb       = b_q[22:0];
        a_zero   = (ea == 8'h00);
        b_zero   = (eb == 8'h00);
        a_inf    = (ea == 8'hFF) && (fa == 23'd0);
        b_inf    = (eb == 8'hFF) && (fb == 23'd0);
        a_nan    = (ea == 8'hFF) && (fa != 23'd0);
        b_nan    = (eb == 8'hFF) && (fb != 23'd0);
        sign_ab  = a_q[31] ^ b_q[31];
        ma       = {1'b1, fa};
        mb       = {1'b1, fb};
        ma_lt    = (ma < mb);
        e_raw    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        e_init   = ma_lt ? (e_raw - 10'sd1) : e_raw;
        rem_init = ma_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};

        is_special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        special_res = '0;
        special_exc = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_res = 32'h7FC0_0000;
            special_exc = 1'b1;
        end else if (a_inf) begin
            special_res = {sign_ab, 8'hFF, 23'd0};
        end else if (b_zero) begin
            special_res = {sign_ab, 8'hFF, 23'd0};
            special_exc = 1'b1;
        end else begin
            special_res = {sign_ab, 31'd0};
        end
    end

    // One restoring-division iteration and the RNE rounding of the final quotient
    always_comb begin
        rem_ge   = (rem_q >= {2'b00, mb_q});
        rem_sub  = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
        rem_next = rem_sub << 1;

        guard      = q_q[0];
        lsb        = q_q[1];
        sticky     = (rem_q != '0);
        inc        = guard & (sticky | lsb);
        frac_sum   = {1'b0, q_q[23:1]} + {23'd0, inc};
        frac_carry = frac_sum[23];
        e_rnd      = e_q + $signed({9'd0, frac_carry});
        rnd_ovf    = (e_rnd >= 10'sd255);
        rnd_unf    = (e_rnd <= 10'sd0);
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = is_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt_q == 5'd24) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, division datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a[31:0];
                        b_q       <= b[31:0];
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        exception <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    sign_q <= sign_ab;
                    e_q    <= e_init;
                    mb_q   <= mb;
                    rem_q  <= rem_init;
                    q_q    <= '0;
                    cnt_q  <= '0;
                    if (is_special) begin
                        result    <= special_res;
                        exception <= special_exc;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[22:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                S_ROUND: begin
                    if (rnd_ovf) begin
                        result   <= {sign_q, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (rnd_unf) begin
                        result    <= {sign_q, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, e_rnd[7:0], frac_sum[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: vector table plus hand-written handshake,
// backpressure and mid-operation reset sequences.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        overflow, underflow, exception;
    logic [31:0] a, b, result;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, exception}
        int          lat;     // edge after acceptance at which out_valid is first sampled high
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fp_div_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called in the negedge phase; returns in the negedge phase with out_valid high
    // (or after a timeout). lat counts edges from the accept edge.
    task automatic do_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                         output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({nm, " in_ready before issue"}, {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held;

        vecs.push_back('{"div6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28});
        vecs.push_back('{"one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 28});
        vecs.push_back('{"neg7_2",     32'hC0E00000, 32'h40000000, 32'hC0600000, 3'b000, 28});
        vecs.push_back('{"five_sixth", 32'h3FA00000, 32'h3FC00000, 32'h3F555555, 3'b000, 28});
        vecs.push_back('{"one_fifth",  32'h3F800000, 32'h40A00000, 32'h3E4CCCCD, 3'b000, 28});
        vecs.push_back('{"max_norm",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 28});
        vecs.push_back('{"min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 28});
        vecs.push_back('{"ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 28});
        vecs.push_back('{"ovf_edge",   32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, 3'b100, 28});
        vecs.push_back('{"unf",        32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 28});
        vecs.push_back('{"unf_edge",   32'h00800000, 32'h3F800001, 32'h00000000, 3'b010, 28});
        vecs.push_back('{"unf_neg",    32'h80800000, 32'h40000000, 32'h80000000, 3'b010, 28});
        vecs.push_back('{"x_div0",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2});
        vecs.push_back('{"zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 3'b001, 2});
        vecs.push_back('{"nan_a",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b001, 2});
        vecs.push_back('{"inf_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b001, 2});
        vecs.push_back('{"inf_x",      32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 2});
        vecs.push_back('{"x_inf",      32'h40000000, 32'hFF800000, 32'h80000000, 3'b000, 2});
        vecs.push_back('{"zero_x",     32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2});
        vecs.push_back('{"denorm_a",   32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 2});
        vecs.push_back('{"denorm_b",   32'hBF800000, 32'h00000001, 32'hFF800000, 3'b001, 2});

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, overflow, underflow, exception}, 32'd0);
        check("reset in_ready low", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Table-driven vectors with out_ready held high
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, " result"}, result, vecs[i].res);
            check({vecs[i].name, " flags"}, {29'd0, overflow, underflow, exception},
                  {29'd0, vecs[i].flags});
            check({vecs[i].name, " latency"}, lat, vecs[i].lat);
            @(negedge clk);
            check({vecs[i].name, " idle after accept"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result held, busy in_valid ignored, release returns to IDLE
        out_ready = 1'b0;
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 6) begin
                check("busy in_ready", {31'd0, in_ready}, 32'd0);
                a = 32'h40C00000;
                b = 32'h40000000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp latency", lat, 28);
        check("bp result", result, 32'h3EAAAAAB);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold result", result, held);
            check("bp hold valid/ready/flags",
                  {27'd0, out_valid, in_ready, overflow, underflow, exception}, 32'h10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset in the middle of a divide, then a fresh op
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort in_ready low", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        do_op("post_rst", 32'h40400000, 32'h3F800000, lat);
        check("post_rst result", result, 32'h40400000);
        check("post_rst latency", lat, 28);
        check("post_rst flags", {29'd0, overflow, underflow, exception}, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
